// File: rtl/ram_pkg.sv
// Shared types for the parametrised register-file RAM.
// The FSM state and the depth helper live here.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  function automatic int depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/ram_word.sv
// One storage word: a DATA_W register with synchronous load.
// Deliberately unreset; the top's clear sequence initialises it.
module ram_word #(
  parameter int DATA_W = 4
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] word_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      word_q <= d_i;
    end
  end

  assign q_o = word_q;

endmodule

// File: rtl/ram_regfile.sv
// Register-file RAM: DEPTH words, one write port, one registered read port,
// with a hardware clear sequence after reset.
module ram_regfile
  import ram_pkg::*;
#(
  parameter int                DATA_W   = 4,
  parameter int                ADDR_W   = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              clk_out
);

  localparam int DEPTH = depth(ADDR_W);
  localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W+1)'(DEPTH - 1);

  state_t            state_q;
  logic [ADDR_W:0]   clr_addr_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_clear;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DEPTH-1:0]  wsel;
  logic [DATA_W-1:0] rd_word;

  assign in_clear = (state_q == CLEAR);

  // Clear sequence owns the write port; reset blocks every write.
  assign wr_en   = !rst && (in_clear || we);
  assign wr_addr = in_clear ? clr_addr_q[ADDR_W-1:0] : waddr;
  assign wr_data = in_clear ? INIT_VAL : wdata;

  always_comb begin
    wsel = '0;
    if (wr_en) begin
      wsel[wr_addr] = 1'b1;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    ram_word #(
      .DATA_W(DATA_W)
    ) u_word (
      .clk_i(clk),
      .en_i (wsel[i]),
      .d_i  (wr_data),
      .q_o  (mem[i])
    );
  end

  // Write-first bypass on a same-address collision.
  assign rd_word = (we && (waddr == raddr)) ? wdata : mem[raddr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      unique case (state_q)
        CLEAR: begin
          clr_addr_q <= clr_addr_q + 1'b1;
          if (clr_addr_q == CLR_LAST) begin
            state_q <= READY;
          end
        end
        READY: begin
          if (re) begin
            rdata_q  <= rd_word;
            rvalid_q <= 1'b1;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  assign rdata   = rdata_q;
  assign rvalid  = rvalid_q;
  assign busy    = in_clear;
  assign clk_out = clk;

endmodule

// File: tb/tb_ram_regfile.sv
// Directed bench for ram_regfile (DATA_W=4, ADDR_W=2, INIT_VAL=4'hA)
// with a reference model and an expected-read queue.
module tb_ram_regfile;

  localparam int DW = 4;
  localparam int AW = 2;
  localparam int DEPTH = 4;
  localparam logic [DW-1:0] IV = 4'hA;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic          re = 1'b0;
  logic [AW-1:0] raddr = '0;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          busy;
  logic          clk_out;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_rdata = '0;
  int            m_clr = 0;
  logic [DW-1:0] exp_q [$];
  int            busy_cycles = 0;

  ram_regfile #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .INIT_VAL(IV)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re     (re),
    .raddr  (raddr),
    .rdata  (rdata),
    .rvalid (rvalid),
    .busy   (busy),
    .clk_out(clk_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive, advance the model, then compare #1 after the edge.
  task automatic cyc(input logic r, input logic w, input logic [AW-1:0] wa,
                     input logic [DW-1:0] wd, input logic rd,
                     input logic [AW-1:0] ra, input string tag);
    logic acc;
    logic [DW-1:0] popped;
    rst = r; we = w; waddr = wa; wdata = wd; re = rd; raddr = ra;
    acc = !r && (m_clr == 0) && rd;
    if (acc) exp_q.push_back((w && wa == ra) ? wd : m_mem[ra]);
    if (!r && m_clr == 0 && w) m_mem[wa] = wd;
    if (r) begin
      m_clr = DEPTH;
      m_rdata = '0;
    end else if (m_clr > 0) begin
      m_mem[DEPTH - m_clr] = IV;
      m_clr--;
    end
    @(posedge clk);
    #1;
    check({tag, ".busy"}, 8'(busy), 8'(m_clr > 0));
    check({tag, ".rvalid"}, 8'(rvalid), 8'(acc));
    if (acc) begin
      popped = exp_q.pop_front();
      m_rdata = popped;
    end
    check({tag, ".rdata"}, 8'(rdata), 8'(m_rdata));
    if (busy === 1'b1) busy_cycles++;
  endtask

  task automatic idle(input string tag);
    cyc(1'b0, 1'b0, '0, '0, 1'b0, '0, tag);
  endtask

  task automatic rd(input logic [AW-1:0] a, input string tag);
    cyc(1'b0, 1'b0, '0, '0, 1'b1, a, tag);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                    input string tag);
    cyc(1'b0, 1'b1, a, d, 1'b0, '0, tag);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

    // 1. reset then clear: busy for exactly DEPTH cycles
    cyc(1'b1, 1'b0, '0, '0, 1'b0, '0, "t1.rst");
    busy_cycles = 0;
    for (int i = 0; i < DEPTH + 1; i++) idle("t1.clear");
    check("t1.busy_len", 8'(busy_cycles), 8'(DEPTH - 1));
    check("t1.clk_out", 8'(clk_out), 8'(clk));
    for (int i = 0; i < DEPTH; i++) rd(AW'(i), "t1.read");
    idle("t1.drain");

    // 2. write then read
    wr(2'd1, 4'h5, "t2.wr");
    rd(2'd1, "t2.rd1");
    rd(2'd0, "t2.rd0");
    rd(2'd3, "t2.rd3");
    idle("t2.drain");

    // 3. write-first collision
    cyc(1'b0, 1'b1, 2'd2, 4'hC, 1'b1, 2'd2, "t3.coll");
    idle("t3.drain");
    rd(2'd2, "t3.rd2");
    cyc(1'b0, 1'b1, 2'd0, 4'h7, 1'b1, 2'd3, "t3.indep");
    rd(2'd0, "t3.rd0");

    // 4. requests during clear are dropped
    cyc(1'b1, 1'b0, '0, '0, 1'b0, '0, "t4.rst");
    for (int i = 0; i < DEPTH; i++)
      cyc(1'b0, 1'b1, AW'(i), 4'hF, 1'b1, AW'(i), "t4.busyreq");
    for (int i = 0; i < DEPTH; i++) rd(AW'(i), "t4.read");
    idle("t4.drain");

    // 5. reset mid-clear restarts the sequence
    cyc(1'b1, 1'b0, '0, '0, 1'b0, '0, "t5.rst1");
    idle("t5.c0");
    idle("t5.c1");
    cyc(1'b1, 1'b1, 2'd0, 4'h3, 1'b1, 2'd0, "t5.rst2");
    busy_cycles = 0;
    for (int i = 0; i < DEPTH + 1; i++) idle("t5.clear");
    check("t5.busy_len", 8'(busy_cycles), 8'(DEPTH - 1));
    for (int i = 0; i < DEPTH; i++) rd(AW'(i), "t5.read");

    // 6. streaming reads after writes 1..4
    for (int i = 0; i < DEPTH; i++) wr(AW'(i), DW'(i + 1), "t6.wr");
    for (int i = 0; i < DEPTH; i++) rd(AW'(i), "t6.stream");
    idle("t6.drain");

    // reset in the middle of a read stream
    rd(2'd1, "t7.rd");
    cyc(1'b1, 1'b0, '0, '0, 1'b1, 2'd2, "t7.rst");
    idle("t7.after");

    check("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
